btn_conditioner: RTL and testbench

- Upstream stage for the board's button-driven logic, such as the LED shifter.
- Takes raw asynchronous push-button pins (btnL, btnR, ...) and synchronizes, debounces and edge-detects each one.
- Produces clean one-cycle press pulses, optional auto-repeat pulses while a button is held, and release pulses.
- Downstream blocks consume btn_pulse directly and need no edge-detect of their own.

---
 rtl/btn_conditioner.sv | 160 ++++++++++++++++
 tb/tb_btn_conditioner.sv | 142 ++++++++++++++
 2 files changed

// File: rtl/btn_conditioner.sv
// Push-button conditioner: per-channel 2-flop synchronizer, debounce FSM,
// registered press / auto-repeat / release pulses and a clean level.
//
//   state        | meaning
//   -------------+---------------------------------------------------------
//   S_IDLE       | button released and stable, level 0
//   S_DB_PRESS   | input went high, counting stable cycles before accepting
//   S_HELD       | press accepted, level 1, auto-repeat timer running
//   S_DB_RELEASE | input went low, counting stable cycles before releasing
module btn_conditioner #(
    parameter int N_BTN           = 2,
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int REPEAT_DELAY    = 50000000,
    parameter int REPEAT_RATE     = 10000000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_BTN-1:0] btn_in,
    output logic [N_BTN-1:0] btn_level,
    output logic [N_BTN-1:0] btn_pulse,
    output logic [N_BTN-1:0] btn_release
);

    localparam int RPT_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
    localparam int DB_W    = $clog2(DEBOUNCE_CYCLES);
    // Guard against a zero-width timer when auto-repeat is off and the rate is 1.
    localparam int RPT_W   = (RPT_MAX > 1) ? $clog2(RPT_MAX) : 1;

    localparam logic [DB_W-1:0]  DB_LAST    = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [RPT_W-1:0] DELAY_LAST = RPT_W'((REPEAT_DELAY > 0) ? REPEAT_DELAY - 1 : 0);
    localparam logic [RPT_W-1:0] RATE_LAST  = RPT_W'(REPEAT_RATE - 1);
    localparam bit               RPT_EN     = (REPEAT_DELAY != 0);

    typedef enum logic [1:0] {
        S_IDLE,
        S_DB_PRESS,
        S_HELD,
        S_DB_RELEASE
    } state_t;

    logic [N_BTN-1:0] sync1_q;
    logic [N_BTN-1:0] sync2_q;

    // Two-flop synchronizer for the asynchronous button pins.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= btn_in;
            sync2_q <= sync1_q;
        end
    end

    for (genvar g = 0; g < N_BTN; g++) begin : g_chan
        state_t           state_q, state_d;
        logic [DB_W-1:0]  cnt_q, cnt_d;
        logic [RPT_W-1:0] rpt_q, rpt_d;
        logic             first_q, first_d;
        logic             level_q, level_d;
        logic             pulse_q, pulse_d;
        logic             rel_q, rel_d;
        logic             sync;

        assign sync = sync2_q[g];

        // Channel state, counters and registered outputs.
        always_ff @(posedge clk) begin
            if (rst) begin
                state_q <= S_IDLE;
                cnt_q   <= '0;
                rpt_q   <= '0;
                first_q <= 1'b0;
                level_q <= 1'b0;
                pulse_q <= 1'b0;
                rel_q   <= 1'b0;
            end else begin
                state_q <= state_d;
                cnt_q   <= cnt_d;
                rpt_q   <= rpt_d;
                first_q <= first_d;
                level_q <= level_d;
                pulse_q <= pulse_d;
                rel_q   <= rel_d;
            end
        end

        // Next-state, debounce counting and auto-repeat timing.
        always_comb begin
            state_d = state_q;
            cnt_d   = cnt_q;
            rpt_d   = rpt_q;
            first_d = first_q;
            level_d = level_q;
            pulse_d = 1'b0;
            rel_d   = 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (sync) begin
                        state_d = S_DB_PRESS;
                        cnt_d   = '0;
                    end
                end
                S_DB_PRESS: begin
                    // A drop always aborts, even on the final count.
                    if (!sync) begin
                        state_d = S_IDLE;
                    end else if (cnt_q == DB_LAST) begin
                        state_d = S_HELD;
                        level_d = 1'b1;
                        pulse_d = 1'b1;
                        rpt_d   = '0;
                        first_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                S_HELD: begin
                    if (!sync) begin
                        state_d = S_DB_RELEASE;
                        cnt_d   = '0;
                    end else if (RPT_EN) begin
                        if (first_q && (rpt_q == DELAY_LAST)) begin
                            pulse_d = 1'b1;
                            rpt_d   = '0;
                            first_d = 1'b0;
                        end else if (!first_q && (rpt_q == RATE_LAST)) begin
                            pulse_d = 1'b1;
                            rpt_d   = '0;
                        end else begin
                            rpt_d = rpt_q + 1'b1;
                        end
                    end
                end
                S_DB_RELEASE: begin
                    // A bounce back high restarts the full repeat delay.
                    if (sync) begin
                        state_d = S_HELD;
                        rpt_d   = '0;
                        first_d = 1'b1;
                    end else if (cnt_q == DB_LAST) begin
                        state_d = S_IDLE;
                        level_d = 1'b0;
                        rel_d   = 1'b1;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end

        assign btn_level[g]   = level_q;
        assign btn_pulse[g]   = pulse_q;
        assign btn_release[g] = rel_q;
    end

endmodule

// File: tb/tb_btn_conditioner.sv
// Directed bench for btn_conditioner with short debounce/repeat timings.
// Every check compares {btn_level, btn_pulse, btn_release} after an edge,
// with edge 1 being the first edge that samples the new input value.
module tb_btn_conditioner;

    logic       clk;
    logic       rst;
    logic [1:0] btn_in;
    logic [1:0] btn_level;
    logic [1:0] btn_pulse;
    logic [1:0] btn_release;

    int checks = 0;
    int errors = 0;

    btn_conditioner #(
        .N_BTN          (2),
        .DEBOUNCE_CYCLES(4),
        .REPEAT_DELAY   (10),
        .REPEAT_RATE    (5)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .btn_in     (btn_in),
        .btn_level  (btn_level),
        .btn_pulse  (btn_pulse),
        .btn_release(btn_release)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input int e, input logic [1:0] lv,
                       input logic [1:0] pu, input logic [1:0] re);
        logic [5:0] obs;
        logic [5:0] exp;
        obs = {btn_level, btn_pulse, btn_release};
        exp = {lv, pu, re};
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s edge %0d observed lvl/pulse/rel=%b expected=%b", tag, e, obs, exp);
        end
    endtask

    initial begin
        rst    = 1'b1;
        btn_in = 2'b00;
        repeat (3) tick();
        chk("reset", 0, 2'b00, 2'b00, 2'b00);
        rst = 1'b0;
        repeat (2) tick();
        chk("idle_after_reset", 0, 2'b00, 2'b00, 2'b00);

        // Clean press on ch0: high for 8 sampled edges.
        btn_in = 2'b01;
        for (int e = 1; e <= 20; e++) begin
            tick();
            chk("clean_press", e, (e >= 7 && e < 15) ? 2'b01 : 2'b00,
                (e == 7) ? 2'b01 : 2'b00, (e == 15) ? 2'b01 : 2'b00);
            if (e == 8) btn_in = 2'b00;
        end
        repeat (3) tick();

        // Bounce on ch1: 1,0,1,0 then low.
        for (int e = 1; e <= 12; e++) begin
            btn_in = (e == 1 || e == 3) ? 2'b10 : 2'b00;
            tick();
            chk("bounce_toggle", e, 2'b00, 2'b00, 2'b00);
        end
        // High for only 3 edges.
        for (int e = 1; e <= 12; e++) begin
            btn_in = (e <= 3) ? 2'b10 : 2'b00;
            tick();
            chk("bounce_short3", e, 2'b00, 2'b00, 2'b00);
        end
        // High for exactly DEBOUNCE_CYCLES edges: the drop lands on the final count.
        for (int e = 1; e <= 12; e++) begin
            btn_in = (e <= 4) ? 2'b10 : 2'b00;
            tick();
            chk("bounce_short4", e, 2'b00, 2'b00, 2'b00);
        end
        // High for DEBOUNCE_CYCLES+1 edges: just accepted.
        for (int e = 1; e <= 16; e++) begin
            btn_in = (e <= 5) ? 2'b10 : 2'b00;
            tick();
            chk("min_press5", e, (e >= 7 && e < 12) ? 2'b10 : 2'b00,
                (e == 7) ? 2'b10 : 2'b00, (e == 12) ? 2'b10 : 2'b00);
        end
        repeat (3) tick();

        // Auto-repeat on ch0: held 40 edges.
        for (int e = 1; e <= 55; e++) begin
            btn_in = (e <= 40) ? 2'b01 : 2'b00;
            tick();
            chk("auto_repeat", e, (e >= 7 && e < 47) ? 2'b01 : 2'b00,
                (e == 7 || e == 17 || e == 22 || e == 27 || e == 32 || e == 37 || e == 42)
                    ? 2'b01 : 2'b00,
                (e == 47) ? 2'b01 : 2'b00);
        end
        repeat (3) tick();

        // Release glitch on ch0: low at edges 10 and 11, back to HELD at edge 14.
        for (int e = 1; e <= 40; e++) begin
            btn_in = (e <= 26 && e != 10 && e != 11) ? 2'b01 : 2'b00;
            tick();
            chk("release_glitch", e, (e >= 7 && e < 33) ? 2'b01 : 2'b00,
                (e == 7 || e == 24) ? 2'b01 : 2'b00, (e == 33) ? 2'b01 : 2'b00);
        end
        repeat (3) tick();

        // Both channels pressed on the same edge.
        btn_in = 2'b11;
        for (int e = 1; e <= 20; e++) begin
            tick();
            chk("simultaneous", e, (e >= 7 && e < 15) ? 2'b11 : 2'b00,
                (e == 7) ? 2'b11 : 2'b00, (e == 15) ? 2'b11 : 2'b00);
            if (e == 8) btn_in = 2'b00;
        end
        repeat (3) tick();

        // Reset pulse at edge 11 while ch0 is HELD; button stays high.
        for (int e = 1; e <= 42; e++) begin
            btn_in = (e <= 30) ? 2'b01 : 2'b00;
            rst    = (e == 11);
            tick();
            chk("reset_mid", e, ((e >= 7 && e <= 10) || (e >= 18 && e < 37)) ? 2'b01 : 2'b00,
                (e == 7 || e == 18 || e == 28) ? 2'b01 : 2'b00, (e == 37) ? 2'b01 : 2'b00);
        end
        rst = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
